// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared definitions for the clock_counter slice: mode encoding, field
//   limits, the blink divisor and the decimal-point masks.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } mode_e;

    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;
    localparam int CSEC_MAX   = 99;

    // 100 Hz ticks, toggle every 50 -> 1 Hz blink period
    localparam int BLINK_DIV  = 50;
    localparam int BLINK_CW   = 6;

    // separators after hour units, minute units and second units
    localparam logic [7:0] RUN_POINT = 8'b0010_1010;

    // In a SET state the two digits of the selected field blink instead.
    function automatic logic [7:0] point_mask(input mode_e m, input logic b);
        logic [7:0] r;
        r = RUN_POINT;
        case (m)
            ST_SET_H: r = {6'b0, b, b};
            ST_SET_M: r = {4'b0, b, b, 2'b0};
            ST_SET_S: r = {2'b0, b, b, 4'b0};
            default:  r = RUN_POINT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Two-digit BCD counter that wraps MAX -> 00.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_inc    : add one this cycle
//   i_clr    : synchronous clear to 00, overrides i_inc
//   o_tens   : registered tens digit
//   o_units  : registered units digit
//   o_carry  : combinational, high when this cycle's increment wraps MAX -> 00
module bcd_mod_counter #(
    parameter int MAX = 99
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_carry
);

    localparam logic [3:0] MAX_T = 4'(MAX / 10);
    localparam logic [3:0] MAX_U = 4'(MAX % 10);

    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic       w_at_max;

    assign w_at_max = (r_tens == MAX_T) && (r_units == MAX_U);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (i_clr) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (i_inc) begin
            if (w_at_max) begin
                r_tens  <= 4'd0;
                r_units <= 4'd0;
            end else if (r_units == 4'd9) begin
                r_tens  <= r_tens + 4'd1;
                r_units <= 4'd0;
            end else begin
                r_units <= r_units + 4'd1;
            end
        end
    end

    assign o_tens  = r_tens;
    assign o_units = r_units;
    assign o_carry = i_inc & w_at_max & ~i_clr;

endmodule

// File: rtl/clock_counter.sv
// clock_counter
//   HH:MM:SS.cc clock with a RUN mode and three SET modes.
//   clk          : clock, rising edge
//   reset_n      : asynchronous active-low reset
//   tick_100hz   : one-cycle 100 Hz enable
//   mode_btn     : one-cycle pulse, RUN -> SET_H -> SET_M -> SET_S -> RUN
//   inc_btn      : one-cycle pulse, +1 on the selected field in SET modes
//   led1..8Number: BCD digits, hour tens .. centisecond units
//   point        : decimal-point mask, point[i] drives led(i+1)
//   mode         : current mode (0 RUN, 1 SET_H, 2 SET_M, 3 SET_S)
module clock_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_100hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] led1Number,
    output logic [3:0] led2Number,
    output logic [3:0] led3Number,
    output logic [3:0] led4Number,
    output logic [3:0] led5Number,
    output logic [3:0] led6Number,
    output logic [3:0] led7Number,
    output logic [3:0] led8Number,
    output logic [7:0] point,
    output logic [1:0] mode
);

    mode_e r_state;
    mode_e w_state_nxt;

    logic                r_blink;
    logic [BLINK_CW-1:0] r_blink_cnt;
    logic                w_blink_wrap;
    logic                w_blink_nxt;
    logic [7:0]          r_point;

    logic w_run;
    logic w_set_inc;
    logic w_cs_inc, w_cs_clr, w_cs_carry;
    logic w_s_inc,  w_s_carry;
    logic w_m_inc,  w_m_carry;
    logic w_h_inc;
    // day rollover has no consumer
    logic w_unused_day_carry;

    // ---------------- mode FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (mode_btn) begin
            case (r_state)
                ST_RUN:   w_state_nxt = ST_SET_H;
                ST_SET_H: w_state_nxt = ST_SET_M;
                ST_SET_M: w_state_nxt = ST_SET_S;
                ST_SET_S: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    // ---------------- counter enables ----------------
    // Carries only ripple while running; in SET modes a field wrap must not
    // touch its neighbour. A mode press masks a coincident inc press.
    assign w_run     = (r_state == ST_RUN);
    assign w_set_inc = inc_btn & ~mode_btn;

    assign w_cs_inc = w_run & tick_100hz;
    assign w_cs_clr = (r_state == ST_SET_S) & mode_btn;
    assign w_s_inc  = (w_run & w_cs_carry) | ((r_state == ST_SET_S) & w_set_inc);
    assign w_m_inc  = (w_run & w_s_carry)  | ((r_state == ST_SET_M) & w_set_inc);
    assign w_h_inc  = (w_run & w_m_carry)  | ((r_state == ST_SET_H) & w_set_inc);

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .i_clk(clk), .i_rst_n(reset_n), .i_inc(w_h_inc), .i_clr(1'b0),
        .o_tens(led1Number), .o_units(led2Number), .o_carry(w_unused_day_carry)
    );

    bcd_mod_counter #(.MAX(MINSEC_MAX)) u_min (
        .i_clk(clk), .i_rst_n(reset_n), .i_inc(w_m_inc), .i_clr(1'b0),
        .o_tens(led3Number), .o_units(led4Number), .o_carry(w_m_carry)
    );

    bcd_mod_counter #(.MAX(MINSEC_MAX)) u_sec (
        .i_clk(clk), .i_rst_n(reset_n), .i_inc(w_s_inc), .i_clr(1'b0),
        .o_tens(led5Number), .o_units(led6Number), .o_carry(w_s_carry)
    );

    bcd_mod_counter #(.MAX(CSEC_MAX)) u_csec (
        .i_clk(clk), .i_rst_n(reset_n), .i_inc(w_cs_inc), .i_clr(w_cs_clr),
        .o_tens(led7Number), .o_units(led8Number), .o_carry(w_cs_carry)
    );

    // ---------------- blink ----------------
    assign w_blink_wrap = tick_100hz && (r_blink_cnt == BLINK_CW'(BLINK_DIV - 1));
    assign w_blink_nxt  = r_blink ^ w_blink_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (tick_100hz) begin
            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            r_blink     <= w_blink_nxt;
        end
    end

    // ---------------- point mux ----------------
    // Built from next-state values so the registered mask lines up with the
    // registered mode and digits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_point <= RUN_POINT;
        else          r_point <= point_mask(w_state_nxt, w_blink_nxt);
    end

    assign point = r_point;
    assign mode  = r_state;

endmodule
